spdif_rate_ctrl: RTL and testbench
==================================

Name: spdif_rate_ctrl

Overview:
- Controller that configures the TOSLINK biphase-mark clock-recovery block for the incoming sample rate: 32k, 44.1k, 48k or 96k.
- Measures the longest inter-edge pulse, which is the 3-cell preamble pulse, over fixed edge windows and classifies it into a rate.
- Confirms the rate over consecutive windows, then drives period/sample_at configuration and lock status to the clock-recovery and downstream S/PDIF decoder.
- Sits between the raw TOSLINK pin and the clock-recovery configuration inputs.

Parameters:
WINDOW_EDGES, 256, edges per measurement window
LOCK_WINDOWS, 2, consecutive matching windows needed to lock
UNLOCK_WINDOWS, 3, consecutive mismatching/invalid windows needed to drop lock
TIMEOUT_CLKS, 4096, clocks without an edge before declaring no signal
MIN_VALID, 16, smallest valid window-max width (clocks)
MAX_VALID, 96, largest valid window-max width (clocks)
TH_96_48, 36, first width classified 48k
TH_48_44, 51, first width classified 44.1k
TH_44_32, 63, first width classified 32k
PERIOD_32 / PERIOD_44 / PERIOD_48 / PERIOD_96, 24 / 18 / 16 / 8, clocks per biphase cell at 100 MHz

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tos_in  input  1  raw asynchronous TOSLINK input
locked  output  1  rate confirmed, config valid
rate_code  output  2  0=32k, 1=44.1k, 2=48k, 3=96k
period  output  6  clocks per cell for clock recovery
sample_at  output  6  sample point = period>>1
cfg_update  output  1  one-cycle pulse when period/sample_at/rate_code change on lock
no_signal  output  1  high while input is idle past timeout

Behaviour:
- Reset values: locked=0, rate_code=2, period=PERIOD_48 (16), sample_at=8, cfg_update=0, no_signal=1. FSM enters SEARCH; all counters clear.
- Input path: 2-FF synchronizer plus one history FF. An edge is any difference between the last two synchronized samples (both polarities).
- Width: number of clk cycles between successive edge pulses (edges at cycles t and t+48 give 48). The counter saturates at 255 and is 8 bits wide.
- The first edge after entering SEARCH only restarts the width counter; its partial pulse is discarded.
- Window tracking: running max of widths plus an edge count. When the count reaches WINDOW_EDGES, the window ends that cycle; the max resets to 0 and the count to 0.
- Window-end classification:
  - max < MIN_VALID or max > MAX_VALID: invalid.
  - [MIN_VALID, TH_96_48-1]: code 3.
  - [TH_96_48, TH_48_44-1]: code 2.
  - [TH_48_44, TH_44_32-1]: code 1.
  - [TH_44_32, MAX_VALID]: code 0.
- FSM:
  - SEARCH: wait for first edge, then go to MEASURE with match_cnt=0.
  - MEASURE, at window end:
    - Invalid: match_cnt=0.
    - Valid code equal to candidate: match_cnt+1.
    - Otherwise: candidate=code, match_cnt=1.
    - When match_cnt reaches LOCK_WINDOWS, go to LOCKED. Load rate_code, period and sample_at the next cycle; locked=1 and cfg_update=1 for exactly that cycle.
  - LOCKED, at window end:
    - Code equal to rate_code: miss_cnt=0.
    - Otherwise: miss_cnt+1.
    - When miss_cnt reaches UNLOCK_WINDOWS, go to SEARCH with locked=0.
- Config hold: period, sample_at and rate_code hold their last locked values while unlocked and change only with cfg_update.
- Relock at the same code still pulses cfg_update.
- Timeout: idle counter clears on every edge. When it reaches TIMEOUT_CLKS in any state: go to SEARCH, locked=0, no_signal=1.
- no_signal clears on the first edge seen after that.
- Simultaneous timeout and window end: timeout wins.
- An edge in the timeout cycle is processed as the first edge of SEARCH.
- Asynchronous reset at any point returns all outputs to reset values immediately.

Test Plan:
- 48k biphase stream (cell=16 clks, preamble long pulse 48-49) -> locked=1 after 2 windows; rate_code=2, period=16, sample_at=8; cfg_update high exactly 1 cycle.
- Locked at 48k, switch to 44.1k (cell 17-18, long pulse 53) -> locked stays 1 for 2 windows and drops at the 3rd window end. Relock: rate_code=1, period=18, sample_at=9, one cfg_update.
- Locked at 48k, inject one window with max=120 (invalid) then resume 48k -> locked stays 1, no cfg_update, miss_cnt returns to 0.
- Hold tos_in constant 4096 clocks while locked -> no_signal=1 and locked=0 on the timeout cycle; period keeps 16.
- 96k stream (long pulse 24) then 32k stream (long pulse 73) -> lock with period=8/sample_at=4, then period=24/sample_at=12.
- Assert reset mid-window after one matching window -> outputs return to reset values; a fresh lock needs 2 full windows.

Source files
------------

// File: rtl/spdif_rate_ctrl.sv
// S/PDIF sample-rate controller: classifies the longest biphase pulse per edge window,
// confirms it over consecutive windows and drives clock-recovery period/sample point.
module spdif_rate_ctrl #(
    parameter int WINDOW_EDGES   = 256,
    parameter int LOCK_WINDOWS   = 2,
    parameter int UNLOCK_WINDOWS = 3,
    parameter int TIMEOUT_CLKS   = 4096,
    parameter int MIN_VALID      = 16,
    parameter int MAX_VALID      = 96,
    parameter int TH_96_48       = 36,
    parameter int TH_48_44       = 51,
    parameter int TH_44_32       = 63,
    parameter int PERIOD_32      = 24,
    parameter int PERIOD_44      = 18,
    parameter int PERIOD_48      = 16,
    parameter int PERIOD_96      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tos_in_i,
    output logic       locked_o,
    output logic [1:0] rate_code_o,
    output logic [5:0] period_o,
    output logic [5:0] sample_at_o,
    output logic       cfg_update_o,
    output logic       no_signal_o
);
    localparam int EW = $clog2(WINDOW_EDGES + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int MW = $clog2(LOCK_WINDOWS + 1);
    localparam int UW = $clog2(UNLOCK_WINDOWS + 1);

    localparam logic [EW-1:0] WIN_LAST = EW'(WINDOW_EDGES - 1);
    localparam logic [TW-1:0] TO_N     = TW'(TIMEOUT_CLKS);
    localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_WINDOWS);
    localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_WINDOWS);
    localparam logic [7:0]    MIN_V    = 8'(MIN_VALID);
    localparam logic [7:0]    MAX_V    = 8'(MAX_VALID);
    localparam logic [7:0]    TH_A     = 8'(TH_96_48);
    localparam logic [7:0]    TH_B     = 8'(TH_48_44);
    localparam logic [7:0]    TH_C     = 8'(TH_44_32);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic [5:0] period_of(input logic [1:0] code);
        logic [5:0] p;
        p = 6'(PERIOD_48);
        case (code)
            2'd0: p = 6'(PERIOD_32);
            2'd1: p = 6'(PERIOD_44);
            2'd2: p = 6'(PERIOD_48);
            2'd3: p = 6'(PERIOD_96);
            default: p = 6'(PERIOD_48);
        endcase
        return p;
    endfunction

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, hist_q;
    logic [7:0]    width_q, width_d;
    logic [7:0]    max_q, max_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [MW-1:0] match_q, match_d, match_n;
    logic [UW-1:0] miss_q, miss_d, miss_n;
    logic [1:0]    cand_q, cand_d;
    logic          locked_q, locked_d;
    logic [1:0]    rate_q, rate_d;
    logic [5:0]    period_q, period_d;
    logic [5:0]    sample_q, sample_d;
    logic          cfg_q, cfg_d;
    logic          nosig_q, nosig_d;

    logic          edge_w, timeout_w, win_end_w, code_ok_w;
    logic [7:0]    cur_max_w;
    logic [1:0]    code_w;

    assign edge_w    = sync2_q ^ hist_q;
    assign timeout_w = (idle_q == TO_N);
    assign cur_max_w = (width_q > max_q) ? width_q : max_q;
    assign win_end_w = edge_w && (state_q != ST_SEARCH) && (edge_cnt_q == WIN_LAST);

    always_comb begin
        code_ok_w = (cur_max_w >= MIN_V) && (cur_max_w <= MAX_V);
        code_w    = 2'd0;
        if (cur_max_w < TH_A)      code_w = 2'd3;
        else if (cur_max_w < TH_B) code_w = 2'd2;
        else if (cur_max_w < TH_C) code_w = 2'd1;
    end

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        edge_cnt_d = edge_cnt_q;
        match_d    = match_q;
        match_n    = match_q;
        miss_d     = miss_q;
        miss_n     = miss_q;
        cand_d     = cand_q;
        locked_d   = locked_q;
        rate_d     = rate_q;
        period_d   = period_q;
        sample_d   = sample_q;
        cfg_d      = 1'b0;
        nosig_d    = nosig_q;

        width_d = edge_w ? 8'd1 : ((width_q == 8'hFF) ? width_q : width_q + 8'd1);
        idle_d  = edge_w ? '0 : (timeout_w ? idle_q : idle_q + 1'b1);
        if (edge_w) nosig_d = 1'b0;

        if (timeout_w) begin
            // An edge landing on the timeout cycle acts as the first edge of a new search.
            locked_d   = 1'b0;
            match_d    = '0;
            miss_d     = '0;
            edge_cnt_d = '0;
            max_d      = '0;
            if (edge_w) begin
                state_d = ST_MEASURE;
            end else begin
                state_d = ST_SEARCH;
                nosig_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (edge_w) begin
                        state_d    = ST_MEASURE;
                        match_d    = '0;
                        edge_cnt_d = '0;
                        max_d      = '0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (win_end_w) begin
                        edge_cnt_d = '0;
                        max_d      = '0;
                        if (state_q == ST_MEASURE) begin
                            if (!code_ok_w) begin
                                match_n = '0;
                            end else if (code_w == cand_q) begin
                                match_n = match_q + 1'b1;
                            end else begin
                                cand_d  = code_w;
                                match_n = 1;
                            end
                            match_d = match_n;
                            if (match_n == LOCK_N) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                                cfg_d    = 1'b1;
                                rate_d   = code_w;
                                period_d = period_of(code_w);
                                sample_d = period_of(code_w) >> 1;
                                match_d  = '0;
                                miss_d   = '0;
                            end
                        end else begin
                            miss_n = (code_ok_w && code_w == rate_q) ? '0 : miss_q + 1'b1;
                            miss_d = miss_n;
                            if (miss_n == UNLOCK_N) begin
                                state_d  = ST_SEARCH;
                                locked_d = 1'b0;
                                miss_d   = '0;
                                match_d  = '0;
                            end
                        end
                    end else if (edge_w) begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                        max_d      = cur_max_w;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            width_q    <= '0;
            max_q      <= '0;
            edge_cnt_q <= '0;
            idle_q     <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            cand_q     <= 2'd2;
            locked_q   <= 1'b0;
            rate_q     <= 2'd2;
            period_q   <= 6'(PERIOD_48);
            sample_q   <= 6'(PERIOD_48 / 2);
            cfg_q      <= 1'b0;
            nosig_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync1_q    <= tos_in_i;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            width_q    <= width_d;
            max_q      <= max_d;
            edge_cnt_q <= edge_cnt_d;
            idle_q     <= idle_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            cand_q     <= cand_d;
            locked_q   <= locked_d;
            rate_q     <= rate_d;
            period_q   <= period_d;
            sample_q   <= sample_d;
            cfg_q      <= cfg_d;
            nosig_q    <= nosig_d;
        end
    end

    assign locked_o     = locked_q;
    assign rate_code_o  = rate_q;
    assign period_o     = period_q;
    assign sample_at_o  = sample_q;
    assign cfg_update_o = cfg_q;
    assign no_signal_o  = nosig_q;

endmodule

// File: tb/tb_spdif_rate_ctrl.sv
// Bench for spdif_rate_ctrl: random biphase-like pulse streams per rate, checked
// window by window against a pulse-list reference model.
module tb_spdif_rate_ctrl;
    localparam int WE     = 32;
    localparam int TO     = 4096;
    localparam int LOCK   = 2;
    localparam int UNLOCK = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tos;
    logic       locked_o;
    logic [1:0] rate_code_o;
    logic [5:0] period_o;
    logic [5:0] sample_at_o;
    logic       cfg_update_o;
    logic       no_signal_o;

    spdif_rate_ctrl #(.WINDOW_EDGES(WE), .TIMEOUT_CLKS(TO)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .tos_in_i     (tos),
        .locked_o     (locked_o),
        .rate_code_o  (rate_code_o),
        .period_o     (period_o),
        .sample_at_o  (sample_at_o),
        .cfg_update_o (cfg_update_o),
        .no_signal_o  (no_signal_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cfg_seen = 0;

    always @(negedge clk) if (cfg_update_o === 1'b1) cfg_seen++;

    // reference model state
    bit m_search, m_locked, m_nosig;
    int m_rate, m_cand, m_match, m_miss, m_n, m_max, m_prev, m_win, m_cfg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s (window %0d): observed=%0d expected=%0d", tag, m_win, obs, exp);
        end
    endtask

    function automatic int classify(input int mx);
        if (mx < 16 || mx > 96) return -1;
        if (mx < 36) return 3;
        if (mx < 51) return 2;
        if (mx < 63) return 1;
        return 0;
    endfunction

    function automatic int period_of(input int r);
        case (r)
            0: return 24;
            1: return 18;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    // prof: 0=48k 1=44.1k 2=96k 3=32k 4=48k with one 120-clock pulse
    function automatic int gen_width(input int prof, input int n);
        int c, l;
        case (prof)
            0: begin c = 16; l = 48 + int'($urandom_range(0, 1)); end
            1: begin c = 17 + int'($urandom_range(0, 1)); l = 53; end
            2: begin c = 8;  l = 24; end
            3: begin c = 24; l = 73; end
            default: begin c = 16; l = (n == 5) ? 120 : 48; end
        endcase
        if (n == 0) return c;
        if (n == 5 || $urandom_range(0, 7) == 0) return l;
        return ($urandom_range(0, 1) == 1) ? 2 * c : c;
    endfunction

    task automatic model_reset();
        m_search = 1; m_locked = 0; m_nosig = 1;
        m_rate = 2; m_cand = -1; m_match = 0; m_miss = 0;
        m_n = 0; m_max = 0; m_prev = 0;
    endtask

    task automatic window_end(input int mx);
        int code;
        code = classify(mx);
        m_win++;
        if (!m_locked) begin
            if (code < 0) m_match = 0;
            else if (code == m_cand) m_match++;
            else begin m_cand = code; m_match = 1; end
            if (m_match == LOCK) begin
                m_locked = 1; m_rate = m_cand; m_cfg++; m_match = 0; m_miss = 0;
            end
        end else begin
            if (code == m_rate) m_miss = 0;
            else m_miss++;
            if (m_miss == UNLOCK) begin
                m_locked = 0; m_search = 1; m_miss = 0; m_match = 0;
            end
        end
    endtask

    task automatic model_edge(output bit ended);
        int w;
        ended = 0;
        m_nosig = 0;
        if (m_search) begin
            m_search = 0; m_n = 0; m_max = 0;
        end else begin
            w = (m_prev > 255) ? 255 : m_prev;
            if (w > m_max) m_max = w;
            m_n++;
            if (m_n == WE) begin
                window_end(m_max);
                m_n = 0; m_max = 0; ended = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("locked", locked_o, m_locked);
        chk("rate_code", rate_code_o, m_rate);
        chk("period", period_o, period_of(m_rate));
        chk("sample_at", sample_at_o, period_of(m_rate) / 2);
        chk("no_signal", no_signal_o, m_nosig);
        chk("cfg_updates", cfg_seen, m_cfg);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_locked"}, locked_o, 0);
        chk({tag, "_rate"}, rate_code_o, 2);
        chk({tag, "_period"}, period_o, 16);
        chk({tag, "_sample"}, sample_at_o, 8);
        chk({tag, "_cfg"}, cfg_update_o, 0);
        chk({tag, "_nosig"}, no_signal_o, 1);
    endtask

    task automatic step(input int prof);
        bit ended;
        int w;
        tos = ~tos;
        model_edge(ended);
        w = gen_width(prof, m_n);
        m_prev = w;
        repeat (5) @(posedge clk);
        #1;
        if (ended) check_outputs();
        repeat (w - 5) @(posedge clk);
        #1;
    endtask

    task automatic run(input int prof, input int nwin);
        int target;
        target = m_win + nwin;
        while (m_win < target) step(prof);
    endtask

    task automatic hold_timeout();
        bit ended;
        tos = ~tos;
        model_edge(ended);
        m_prev = 255;
        repeat (5) @(posedge clk);
        #1;
        if (ended) check_outputs();
        repeat (TO + 5) @(posedge clk);
        #1;
        m_search = 1; m_locked = 0; m_nosig = 1; m_match = 0; m_miss = 0;
        chk("timeout_locked", locked_o, 0);
        chk("timeout_nosig", no_signal_o, 1);
        chk("timeout_period", period_o, 16);
        chk("timeout_rate", rate_code_o, m_rate);
        repeat (100) @(posedge clk);
        #1;
    endtask

    initial begin
        int cfg_before;
        m_win = 0; m_cfg = 0;
        model_reset();
        reset = 1'b1;
        tos   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // one matching window, then reset mid-window
        run(0, 1);
        chk("pre_reset_locked", locked_o, 0);
        repeat (10) step(0);
        #3 reset = 1'b1;
        #1;
        check_reset_vals("async");
        tos = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run(0, 1);
        chk("fresh_w1_locked", locked_o, 0);
        run(0, 1);
        chk("lock48_locked", locked_o, 1);
        chk("lock48_rate", rate_code_o, 2);
        chk("lock48_cfg", cfg_seen, 1);

        // invalid window while locked must not disturb lock
        run(4, 1);
        chk("invalid_locked", locked_o, 1);
        run(0, 1);

        // switch to 44.1k: survives two windows, drops on the third
        run(1, 2);
        chk("sw44_hold", locked_o, 1);
        run(1, 1);
        chk("sw44_drop", locked_o, 0);
        chk("sw44_period_held", period_o, 16);
        cfg_before = cfg_seen;
        run(1, 2);
        chk("lock44_locked", locked_o, 1);
        chk("lock44_rate", rate_code_o, 1);
        chk("lock44_period", period_o, 18);
        chk("lock44_sample", sample_at_o, 9);
        chk("lock44_one_cfg", cfg_seen - cfg_before, 1);

        // back to 48k, then lose the signal
        run(0, 3);
        run(0, 2);
        chk("relock48_rate", rate_code_o, 2);
        hold_timeout();

        // 96k then 32k
        run(2, 2);
        chk("lock96_period", period_o, 8);
        chk("lock96_sample", sample_at_o, 4);
        run(3, 3);
        run(3, 2);
        chk("lock32_locked", locked_o, 1);
        chk("lock32_period", period_o, 24);
        chk("lock32_sample", sample_at_o, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
